lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store initiator that turns single pipeline memory requests into accesses on the word-wide data memory.
- The data memory has a combinational read, a write on the clock edge when we=1, and a word-index address.
- Supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Sub-word stores are done as read-modify-write; misaligned requests are flagged and never reach memory.
- Sits between the MEM stage and the data memory, using valid/ready handshakes on both request and response.

Parameters:
- DATA_WIDTH, 32 (from mips_pkg): data word width; byte-lane logic is fixed at 4 lanes, so only 32 is legal.
- WORDS_INSTRUCTION, from mips_pkg: memory depth in words.
- ADDR_W, $clog2(WORDS_INSTRUCTION)+2: request byte-address width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as misaligned).
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_WIDTH  load result, extended; 0 for stores and errors.
- rsp_err  out  1  misaligned or reserved-size request.
- dm_we  out  1  to memory we.
- dm_address  out  ADDR_W-2  to memory address (word index).
- dm_wdata  out  DATA_WIDTH  to memory data_in.
- dm_rdata  in  DATA_WIDTH  from memory data_out (combinational).

Behaviour:
- Clock and reset: single clock clk; rst_n is synchronous and active-low.
- Reset: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, dm_we = 0, dm_address = 0, dm_wdata = 0, all request latches cleared.
- Reset mid-operation: takes effect at the next edge and aborts any access; dm_we is 0 during and after reset, so no partial write occurs.
- Byte order is little-endian: lane k = bits [8k+7:8k], selected by addr[1:0]. A halfword uses lanes {addr[1]*2+1, addr[1]*2}.
- Alignment:
  - A halfword needs addr[0] = 0.
  - A word needs addr[1:0] = 00.
  - Size 11 is always an error.
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch the request.
  - If misaligned, go to RESP with rsp_err = 1 and rsp_rdata = 0. No dm access.
  - Otherwise go to ACCESS.
- ACCESS:
  - req_ready = 0; dm_address = latched addr[ADDR_W-1:2].
  - Load: extract the selected lane(s) from dm_rdata, extend per req_signed, register into rsp_rdata, then go to RESP.
  - Word store: dm_we = 1, dm_wdata = req_wdata, then go to RESP.
  - Byte or halfword store: register merged = dm_rdata with the selected lane(s) replaced by req_wdata[7:0] or [15:0], then go to WRITE.
- WRITE: dm_we = 1, dm_wdata = merged, same dm_address, then go to RESP.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err stay stable.
  - When rsp_ready = 1 at an edge, go to IDLE and clear rsp_valid.
  - The controller holds indefinitely while rsp_ready = 0.
- Default outputs: dm_we = 0 in every state except as listed. dm_address and dm_wdata may hold their previous values when dm_we = 0.
- Latency from the accept edge to rsp_valid high:
  - Error: 1 cycle.
  - Load or word store: 2 cycles.
  - Sub-word store: 3 cycles.
- Throughput: one request in flight. There is no accept in RESP, so a new request is taken earliest in the cycle after the response handshake.
- Independence: req_* may change freely after acceptance; only the latched copies are used.
- Extension: a sign-extended byte replicates bit 7 and a halfword replicates bit 15; zero extension pads with 0s.
- Wrap-around: none. The word index is taken directly and only the highest address is boundary-tested.

Test Plan:
- Word store then load: store addr 0x010 data 0xDEADBEEF, then load word 0x010. Required: one dm_we pulse at index 4 with 0xDEADBEEF; load rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid 2 cycles after accept.
- Byte read-modify-write: with word 4 = 0xDEADBEEF, store byte 0x013 data 0x000000A5. Required: dm_we in WRITE only, dm_wdata = 0xA5ADBEEF. Then a signed byte load of 0x013 returns 0xFFFFFFA5 and an unsigned one returns 0x000000A5.
- Halfword load at 0x012 on 0xA5ADBEEF: signed returns 0xFFFFA5AD, unsigned returns 0x0000A5AD. A halfword store 0x1234 at 0x010 gives 0xA5AD1234.
- Misaligned requests: word load at 0x011, halfword store at 0x013, size 11. Required: rsp_err = 1 one cycle after accept, rsp_rdata = 0, dm_we never asserted, memory unchanged.
- Back-pressure: hold rsp_ready = 0 for 5 cycles after a load. Required: rsp_valid stays 1 with a stable rsp_rdata, req_ready = 0, and a request held on req_valid is not accepted until the cycle after rsp_ready = 1.
- Reset in WRITE: assert rst_n = 0 during the WRITE cycle of a byte store. Required: no dm_we at that edge, all outputs at reset values, memory word unchanged, and req_ready = 1 after release.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store initiator between the MEM stage and a word-wide data memory.
// Sub-word stores are read-modify-write; misaligned requests never reach memory.
package mips_pkg;
    localparam int DATA_WIDTH        = 32;
    localparam int WORDS_INSTRUCTION = 256;
    localparam int ADDR_W            = $clog2(WORDS_INSTRUCTION) + 2;
endpackage

module lsu_ctrl
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  dm_we,
    output logic [ADDR_W-3:0]     dm_address,
    output logic [DATA_WIDTH-1:0] dm_wdata,
    input  logic [DATA_WIDTH-1:0] dm_rdata
);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WRITE,
        S_RESP
    } state_t;

    state_t                r_state;
    logic                  r_we;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic [1:0]            r_off;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_dm_we;
    logic [ADDR_W-3:0]     r_dm_address;
    logic [DATA_WIDTH-1:0] r_dm_wdata;

    logic                  w_misaligned;
    logic                  w_word_store;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] w_ins;
    logic [DATA_WIDTH-1:0] w_merged;

    always_comb begin
        w_misaligned = 1'b0;
        unique case (req_size)
            SZ_B:    w_misaligned = 1'b0;
            SZ_H:    w_misaligned = req_addr[0];
            SZ_W:    w_misaligned = |req_addr[1:0];
            default: w_misaligned = 1'b1;
        endcase
    end

    assign w_word_store = req_we && (req_size == SZ_W);

    always_comb begin
        w_byte = dm_rdata[7:0];
        unique case (r_off)
            2'd0:    w_byte = dm_rdata[7:0];
            2'd1:    w_byte = dm_rdata[15:8];
            2'd2:    w_byte = dm_rdata[23:16];
            default: w_byte = dm_rdata[31:24];
        endcase
    end

    assign w_half = r_off[1] ? dm_rdata[31:16] : dm_rdata[15:0];

    always_comb begin
        w_load = dm_rdata;
        unique case (r_size)
            SZ_B:    w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            SZ_H:    w_load = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load = dm_rdata;
        endcase
    end

    // Replicate the store data over every lane, then let the mask pick the target lanes.
    always_comb begin
        w_mask = '1;
        w_ins  = r_wdata;
        unique case (r_size)
            SZ_B: begin
                w_mask = 32'h0000_00FF << {r_off, 3'b000};
                w_ins  = {4{r_wdata[7:0]}};
            end
            SZ_H: begin
                w_mask = 32'h0000_FFFF << {r_off[1], 4'b0000};
                w_ins  = {2{r_wdata[15:0]}};
            end
            default: begin
                w_mask = '1;
                w_ins  = r_wdata;
            end
        endcase
    end

    assign w_merged = (dm_rdata & ~w_mask) | (w_ins & w_mask);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_off        <= 2'b00;
            r_wdata      <= '0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
            r_dm_we      <= 1'b0;
            r_dm_address <= '0;
            r_dm_wdata   <= '0;
        end else begin
            r_dm_we <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we         <= req_we;
                        r_size       <= req_size;
                        r_signed     <= req_signed;
                        r_off        <= req_addr[1:0];
                        r_wdata      <= req_wdata;
                        r_req_ready  <= 1'b0;
                        r_rsp_rdata  <= '0;
                        r_rsp_err    <= w_misaligned;
                        if (w_misaligned) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state      <= S_ACCESS;
                            r_dm_address <= req_addr[ADDR_W-1:2];
                            if (w_word_store) begin
                                r_dm_we    <= 1'b1;
                                r_dm_wdata <= req_wdata;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (!r_we) begin
                        r_rsp_rdata <= w_load;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_size == SZ_W) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_dm_wdata <= w_merged;
                        r_dm_we    <= 1'b1;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Gate with reset so an edge that lands during reset can never commit a write.
    assign dm_we      = r_dm_we & rst_n;
    assign dm_address = r_dm_address;
    assign dm_wdata   = r_dm_wdata;
    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: directed plan steps plus random traffic
// checked against a byte-addressed reference memory.
module tb_lsu_ctrl;
    import mips_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic                  req_we = 1'b0;
    logic [1:0]            req_size = 2'b00;
    logic                  req_signed = 1'b0;
    logic [ADDR_W-1:0]     req_addr = '0;
    logic [DATA_WIDTH-1:0] req_wdata = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  dm_we;
    logic [ADDR_W-3:0]     dm_address;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [DATA_WIDTH-1:0] dm_rdata;

    logic [31:0] mem [WORDS_INSTRUCTION];
    logic [7:0]  rb  [4*WORDS_INSTRUCTION];
    int          we_cnt = 0;
    int          nvec = 0;
    int          nerr = 0;

    lsu_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .dm_we      (dm_we),
        .dm_address (dm_address),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata)
    );

    always #5 clk = ~clk;

    assign dm_rdata = mem[dm_address];

    always @(posedge clk) begin
        if (dm_we) begin
            mem[dm_address] <= dm_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_err(input logic [1:0] sz, input int a);
        int n;
        if (sz == 2'b11) return 1'b1;
        n = 1 << sz;
        return (a % n) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit sg, input int a);
        int     n;
        longint v;
        n = 1 << sz;
        v = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(rb[a+i]) << (8*i));
        if (sg && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
    endfunction

    logic [31:0] cur_exp;

    task automatic start_req(input bit we, input logic [1:0] sz, input bit sg,
                             input int a, input logic [31:0] wd, input string tag);
        bit e;
        int exp_lat;
        int lat;
        int w0;
        e       = ref_err(sz, a);
        cur_exp = (e || we) ? 32'h0 : ref_load(sz, sg, a);
        exp_lat = e ? 1 : ((!we || sz == 2'b10) ? 2 : 3);
        chk({tag, "/req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = ADDR_W'(a);
        req_wdata  = wd;
        w0         = we_cnt;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = ADDR_W'($urandom);
        req_wdata  = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/rsp_err"}, 32'(rsp_err), 32'(e));
        chk({tag, "/rsp_rdata"}, rsp_rdata, cur_exp);
        chk({tag, "/req_ready_busy"}, 32'(req_ready), 32'd0);
        if (we && !e)
            for (int i = 0; i < (1 << sz); i++) rb[a+i] = wd[8*i +: 8];
        chk({tag, "/we_pulses"}, 32'(we_cnt - w0), (we && !e) ? 32'd1 : 32'd0);
        chk({tag, "/mem_word"}, mem[a >> 2], ref_word(a >> 2));
    endtask

    task automatic finish_req(input int bp, input string tag);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk({tag, "/bp_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "/bp_rdata"}, rsp_rdata, cur_exp);
            chk({tag, "/bp_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "/rsp_valid_clr"}, 32'(rsp_valid), 32'd0);
        chk({tag, "/req_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    task automatic do_req(input bit we, input logic [1:0] sz, input bit sg, input int a,
                          input logic [31:0] wd, input int bp, input string tag);
        start_req(we, sz, sg, a, wd, tag);
        finish_req(bp, tag);
    endtask

    initial begin
        logic [31:0] keep;
        int          w0;
        int          bad;

        for (int w = 0; w < WORDS_INSTRUCTION; w++) begin
            mem[w] = $urandom;
            for (int k = 0; k < 4; k++) rb[4*w+k] = mem[w][8*k +: 8];
        end

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/req_ready", 32'(req_ready), 32'd1);
        chk("rst/rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst/rsp_rdata", rsp_rdata, 32'd0);
        chk("rst/rsp_err", 32'(rsp_err), 32'd0);
        chk("rst/dm_we", 32'(dm_we), 32'd0);
        chk("rst/dm_address", 32'(dm_address), 32'd0);
        chk("rst/dm_wdata", dm_wdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(1'b1, 2'b10, 1'b0, 'h010, 32'hDEADBEEF, 0, "sw");
        chk("sw/word4", mem[4], 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 'h010, 32'h0, 0, "lw");
        do_req(1'b1, 2'b00, 1'b0, 'h013, 32'h000000A5, 0, "sb");
        chk("sb/word4", mem[4], 32'hA5ADBEEF);
        do_req(1'b0, 2'b00, 1'b1, 'h013, 32'h0, 0, "lb");
        do_req(1'b0, 2'b00, 1'b0, 'h013, 32'h0, 0, "lbu");
        do_req(1'b0, 2'b01, 1'b1, 'h012, 32'h0, 0, "lh");
        do_req(1'b0, 2'b01, 1'b0, 'h012, 32'h0, 0, "lhu");
        do_req(1'b1, 2'b01, 1'b0, 'h010, 32'h00001234, 0, "sh");
        chk("sh/word4", mem[4], 32'hA5AD1234);

        do_req(1'b0, 2'b10, 1'b0, 'h011, 32'h0, 0, "mis_lw");
        do_req(1'b1, 2'b01, 1'b0, 'h013, 32'hFFFF5555, 0, "mis_sh");
        do_req(1'b0, 2'b11, 1'b1, 'h010, 32'h0, 0, "mis_sz3");
        chk("mis/word4", mem[4], 32'hA5AD1234);

        start_req(1'b0, 2'b10, 1'b0, 'h010, 32'h0, "bp");
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = ADDR_W'('h012);
        finish_req(5, "bp");
        do_req(1'b0, 2'b00, 1'b0, 'h012, 32'h0, 0, "bp_next");

        do_req(1'b1, 2'b10, 1'b0, 'h3FC, 32'h80FF7F01, 0, "top_sw");
        do_req(1'b0, 2'b00, 1'b1, 'h3FF, 32'h0, 0, "top_lb");
        do_req(1'b0, 2'b01, 1'b1, 'h3FE, 32'h0, 1, "top_lh");
        do_req(1'b1, 2'b00, 1'b0, 'h3FF, 32'h0000003C, 0, "top_sb");

        w0   = we_cnt;
        keep = mem[5];
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = ADDR_W'('h015);
        req_wdata  = 32'h00000077;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rw/we_in_write", 32'(dm_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rw/we_gated", 32'(dm_we), 32'd0);
        @(posedge clk); #1;
        chk("rw/we_pulses", 32'(we_cnt - w0), 32'd0);
        chk("rw/word5", mem[5], keep);
        chk("rw/word5_ref", mem[5], ref_word(5));
        chk("rw/req_ready", 32'(req_ready), 32'd1);
        chk("rw/rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rw/rsp_rdata", rsp_rdata, 32'd0);
        chk("rw/rsp_err", 32'(rsp_err), 32'd0);
        chk("rw/dm_address", 32'(dm_address), 32'd0);
        chk("rw/dm_wdata", dm_wdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rw/req_ready_after", 32'(req_ready), 32'd1);
        chk("rw/dm_we_after", 32'(dm_we), 32'd0);

        for (int t = 0; t < 80; t++) begin
            logic [1:0] sz;
            int         a;
            sz = 2'($urandom_range(0, 3));
            a  = int'($urandom_range(0, 4*WORDS_INSTRUCTION - 1));
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((1 << sz) - 1);
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                   $urandom, int'($urandom_range(0, 2)), "rnd");
        end

        bad = 0;
        for (int w = 0; w < WORDS_INSTRUCTION; w++)
            if (mem[w] !== ref_word(w)) bad++;
        chk("memscan", 32'(bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
